// File: rtl/systolic_drain.sv
// Drains the MAC array C accumulators row by row, bottom row first, onto a valid/ready stream.
// Each row takes one LOAD cycle (shift + capture) and then waits in SEND for the downstream handshake.
module systolic_drain #(
  parameter  int DIM    = 4,
  parameter  int BITS_C = 16,
  localparam int ROWW   = ($clog2(DIM) > 1) ? $clog2(DIM) : 1,
  localparam int W      = DIM * BITS_C
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            wr_en,
  output logic [W-1:0]    c_head,
  input  logic [W-1:0]    c_tail,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [ROWW-1:0] out_row,
  output logic            out_last,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [ROWW-1:0] LAST = ROWW'(DIM - 1);

  state_t          state;
  state_t          state_nxt;
  logic [ROWW-1:0] cnt;
  logic            last_row;
  logic            hs;

  assign last_row = (cnt == LAST);
  assign hs       = out_valid & out_ready;

  // Zeros enter the top of the chain so the array is clear once all rows have shifted out.
  assign c_head   = '0;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        wr_en     = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (hs) state_nxt = last_row ? IDLE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) cnt <= '0;
        end
        // c_tail is the bottom row being pushed out by the shift happening at this same edge.
        LOAD: begin
          out_data  <= c_tail;
          out_row   <= LAST - cnt;
          out_last  <= last_row;
          out_valid <= 1'b1;
        end
        SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            if (last_row) done <= 1'b1;
            else          cnt  <= cnt + ROWW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: models the array column chain and checks the stream against a row-queue reference.
module tb_systolic_drain;

  localparam int DIM    = 4;
  localparam int BITS_C = 16;
  localparam int W      = DIM * BITS_C;
  localparam int ROWW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b1;
  logic            busy;
  logic            wr_en;
  logic [W-1:0]    c_head;
  logic [W-1:0]    c_tail;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    out_data;
  logic [ROWW-1:0] out_row;
  logic            out_last;
  logic            done;

  systolic_drain #(.DIM(DIM), .BITS_C(BITS_C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .wr_en     (wr_en),
    .c_head    (c_head),
    .c_tail    (c_tail),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Array column chain: each wr_en shifts rows down, c_head enters row 0, row DIM-1 is c_tail.
  logic [W-1:0] mem [DIM];
  logic [W-1:0] pre_val [DIM];
  logic         pre_req = 1'b0;

  assign c_tail = mem[DIM-1];

  always @(posedge clk) begin
    if (pre_req) begin
      for (int r = 0; r < DIM; r++) mem[r] <= pre_val[r];
    end else if (wr_en) begin
      for (int r = DIM - 1; r > 0; r--) mem[r] <= mem[r-1];
      mem[0] <= c_head;
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = stall gap cycles per row.
  int rdy_mode  = 0;
  int gap       = 0;
  int stall_cnt = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (out_valid && stall_cnt < gap) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
          if (!out_valid) stall_cnt = 0;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Reference: a drain accepted at start snapshots the array, rows leave bottom-first one per handshake.
  typedef struct {
    logic [W-1:0]    data;
    logic [ROWW-1:0] row;
    logic            last;
  } exp_t;

  exp_t         q[$];
  int           m_rows  = 0;
  logic         m_wr    = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_done  = 1'b0;
  int           hs_cnt  = 0;
  logic [W-1:0] cap [DIM];

  always @(negedge clk) begin
    logic hs, acc, n_wr, n_valid, n_done;
    exp_t e;
    chk("wr_en", wr_en, m_wr);
    chk("out_valid", out_valid, m_valid);
    chk("done", done, m_done);
    chk("busy", busy, m_rows != 0);
    if (m_valid && q.size() > 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_row", out_row, q[0].row);
      chk("out_last", out_last, q[0].last);
    end
    hs = m_valid && out_ready;
    if (!rst_n) begin
      m_rows  = 0;
      m_wr    = 1'b0;
      m_valid = 1'b0;
      m_done  = 1'b0;
      q.delete();
    end else begin
      acc     = start && (m_rows == 0);
      n_done  = hs && (m_rows == 1);
      n_wr    = acc || (hs && m_rows > 1);
      n_valid = m_wr || (m_valid && !hs);
      if (hs) begin
        if (q.size() > 0) begin
          cap[q[0].row] = out_data;
          void'(q.pop_front());
        end
        hs_cnt++;
        m_rows--;
      end
      if (acc) begin
        m_rows = DIM;
        for (int i = 0; i < DIM; i++) begin
          e.data = mem[DIM-1-i];
          e.row  = ROWW'(DIM - 1 - i);
          e.last = (i == DIM - 1);
          q.push_back(e);
        end
      end
      m_wr    = n_wr;
      m_valid = n_valid;
      m_done  = n_done;
    end
  end

  task automatic preload(input logic [DIM-1:0][W-1:0] p);
    for (int r = 0; r < DIM; r++) pre_val[r] = p[r];
    pre_req = 1'b1;
    tick();
    pre_req = 1'b0;
  endtask

  task automatic clear_cap();
    for (int r = 0; r < DIM; r++) cap[r] = 'x;
  endtask

  task automatic wait_done(input int budget, output int el);
    int n = 0;
    el = -1;
    while (n < budget) begin
      @(negedge clk);
      if (done === 1'b1) begin
        el = cyc - c0;
        break;
      end
      n++;
    end
    if (el < 0) chk("done timeout", 0, 1);
  endtask

  task automatic wait_row(input int row);
    int  n  = 0;
    bit  ok = 0;
    while (n < 200 && !ok) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_row == ROWW'(row)) ok = 1;
      n++;
    end
    if (!ok) chk("row wait timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) chk("idle timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " out_row"}, out_row, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " wr_en"}, wr_en, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " c_head"}, c_head, 0);
  endtask

  typedef struct {
    logic [DIM-1:0][W-1:0] pre;
    int                    gap;
    int                    exp_cyc;
    logic [DIM-1:0][W-1:0] exp_row;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int el;
    int hs0;

    vecs[0].pre     = {64'h33A5_32A5_31A5_30A5, 64'h23A5_22A5_21A5_20A5,
                       64'h13A5_12A5_11A5_10A5, 64'h03A5_02A5_01A5_00A5};
    vecs[0].gap     = 0;
    vecs[0].exp_cyc = 9;
    vecs[0].exp_row = {64'h33A5_32A5_31A5_30A5, 64'h23A5_22A5_21A5_20A5,
                       64'h13A5_12A5_11A5_10A5, 64'h03A5_02A5_01A5_00A5};
    vecs[1].pre     = {64'hDEAD_BEEF_0123_4567, 64'h0001_7FFF_FFFF_8000,
                       64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1].gap     = 0;
    vecs[1].exp_cyc = 9;
    vecs[1].exp_row = {64'hDEAD_BEEF_0123_4567, 64'h0001_7FFF_FFFF_8000,
                       64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2].pre     = {64'hA3A3_B3B3_C3C3_D3D3, 64'hA2A2_B2B2_C2C2_D2D2,
                       64'hA1A1_B1B1_C1C1_D1D1, 64'hA0A0_B0B0_C0C0_D0D0};
    vecs[2].gap     = 5;
    vecs[2].exp_cyc = 29;
    vecs[2].exp_row = {64'hA3A3_B3B3_C3C3_D3D3, 64'hA2A2_B2B2_C2C2_D2D2,
                       64'hA1A1_B1B1_C1C1_D1D1, 64'hA0A0_B0B0_C0C0_D0D0};

    // Reset held with start high: nothing may start.
    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    start = 1'b0;
    tick();

    for (int v = 0; v < 3; v++) begin
      preload(vecs[v].pre);
      gap      = vecs[v].gap;
      rdy_mode = (vecs[v].gap != 0) ? 2 : 0;
      clear_cap();
      start = 1'b1;
      c0    = cyc;
      tick();
      start = 1'b0;
      wait_done(300, el);
      chk($sformatf("vec%0d latency", v), el, vecs[v].exp_cyc);
      for (int r = 0; r < DIM; r++) begin
        chk($sformatf("vec%0d row%0d data", v, r), cap[r], vecs[v].exp_row[r]);
        chk($sformatf("vec%0d array row%0d cleared", v, r), mem[r], 0);
      end
      tick();
    end
    rdy_mode = 0;

    // start during a drain is ignored; start in the done cycle begins a second drain.
    preload(vecs[0].pre);
    hs0   = hs_cnt;
    start = 1'b1;
    c0    = cyc;
    tick();
    start = 1'b0;
    wait_row(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, el);
    chk("busy-start latency", el, 9);
    chk("busy-start row count", hs_cnt - hs0, DIM);
    start = 1'b1;
    hs0   = hs_cnt;
    c0    = cyc;
    clear_cap();
    tick();
    start = 1'b0;
    wait_done(100, el);
    chk("done-cycle start latency", el, 9);
    chk("done-cycle start row count", hs_cnt - hs0, DIM);
    for (int r = 0; r < DIM; r++) chk($sformatf("second drain row%0d zero", r), cap[r], 0);
    tick();

    // Reset lands on the edge of the second handshake: two rows have shifted out.
    preload(vecs[0].pre);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_row(2);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("mid reset");
    rst_n = 1'b1;
    tick();
    clear_cap();
    start = 1'b1;
    c0    = cyc;
    tick();
    start = 1'b0;
    wait_done(100, el);
    chk("post-reset latency", el, 9);
    chk("post-reset row3", cap[3], 64'h13A5_12A5_11A5_10A5);
    chk("post-reset row2", cap[2], 64'h03A5_02A5_01A5_00A5);
    chk("post-reset row1", cap[1], 0);
    chk("post-reset row0", cap[0], 0);
    tick();

    // Random preloads, random start pulses and random backpressure.
    for (int it = 0; it < 8; it++) begin
      logic [DIM-1:0][W-1:0] p;
      start    = 1'b0;
      rdy_mode = 0;
      tick();
      wait_idle();
      for (int r = 0; r < DIM; r++) p[r] = {$urandom, $urandom};
      preload(p);
      rdy_mode = 1;
      repeat (80) begin
        start = ($urandom_range(0, 5) == 0);
        tick();
      end
    end
    start    = 1'b0;
    rdy_mode = 0;
    tick();
    wait_idle();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
